// File: rtl/mvm_uart_pkg.sv
// Shared UART definitions for the MVM link: frame defaults, counter sizing, byte packing, FSM states.
// UART_TX_PARITY_EN moves one post-data slot from stop bit to even parity.
package mvm_uart_pkg;

   localparam int CLOCKS_PER_PULSE_DEF = 4;
   localparam int BITS_PER_WORD_DEF    = 8;
   localparam int PACKET_SIZE_TX_DEF   = 13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   function automatic int calc_nb(input int w, input int bpw);
      return (w + bpw - 1) / bpw;
   endfunction

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int stop_bits(input int pkt, input int bpw);
`ifdef UART_TX_PARITY_EN
      return pkt - bpw - 2;
`else
      return pkt - bpw - 1;
`endif
   endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Byte serialiser: one frame per accepted byte; byte_rdy_o rises in the last cycle of a frame so frames
// chain without a gap. UART_TX_PARITY_EN puts even parity in the first post-data slot.
module uart_tx_frame
   import mvm_uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
   parameter int BITS_PER_WORD    = BITS_PER_WORD_DEF,
   parameter int PACKET_SIZE_TX   = PACKET_SIZE_TX_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [BITS_PER_WORD-1:0] byte_dat_i,
   input  logic                     byte_vld_i,
   output logic                     byte_rdy_o,
   output logic                     frame_end_o,
   output logic                     tx_o
);

   localparam int BAUD_W = cnt_w(CLOCKS_PER_PULSE - 1);
   localparam int BIT_W  = cnt_w(PACKET_SIZE_TX - 1);
`ifdef UART_TX_PARITY_EN
   localparam int PAR_SLOTS = 1;
`else
   localparam int PAR_SLOTS = 0;
`endif
   localparam int LAST_BIT = BITS_PER_WORD + PAR_SLOTS + stop_bits(PACKET_SIZE_TX, BITS_PER_WORD);

   uart_state_e              state_q, state_d;
   logic [BAUD_W-1:0]        baud_q, baud_d;
   logic [BIT_W-1:0]         bit_q, bit_d, bit_nx;
   logic [BITS_PER_WORD-1:0] sh_q, sh_d;
   logic                     tx_q, tx_d;
   logic                     baud_end;
`ifdef UART_TX_PARITY_EN
   logic                     par_q, par_d;
`endif

   assign baud_end    = (baud_q == BAUD_W'(CLOCKS_PER_PULSE - 1));
   assign bit_nx      = bit_q + BIT_W'(1);
   assign frame_end_o = (state_q == ST_STOP) && baud_end && (bit_q == BIT_W'(LAST_BIT));
   assign byte_rdy_o  = (state_q == ST_IDLE) || frame_end_o;
   assign tx_o        = tx_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (byte_vld_i && byte_rdy_o) begin
         state_d = ST_START;
         baud_d  = '0;
         bit_d   = '0;
         sh_d    = byte_dat_i;
         tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^byte_dat_i;
`endif
      end else if (frame_end_o) begin
         state_d = ST_IDLE;
         baud_d  = '0;
         bit_d   = '0;
         tx_d    = 1'b1;
      end else if (state_q != ST_IDLE) begin
         if (baud_end) begin
            baud_d = '0;
            bit_d  = bit_nx;
            // tx is registered, so it is loaded with the value of the slot being entered
            if (bit_nx <= BIT_W'(BITS_PER_WORD)) begin
               state_d = ST_DATA;
               tx_d    = sh_q[0];
               sh_d    = sh_q >> 1;
            end else begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
               if (bit_nx == BIT_W'(BITS_PER_WORD + 1)) tx_d = par_q;
`endif
            end
         end else begin
            baud_d = baud_q + BAUD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: rtl/mvm_uart_tx_packer.sv
// Holds one result vector and feeds its sign-extended little-endian bytes to the frame serialiser;
// tx starts one cycle after the handshake, s_valid is ignored while busy. Parity via UART_TX_PARITY_EN.
module mvm_uart_tx_packer
   import mvm_uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
   parameter int BITS_PER_WORD    = BITS_PER_WORD_DEF,
   parameter int PACKET_SIZE_TX   = PACKET_SIZE_TX_DEF,
   parameter int W_Y_OUT          = 10,
   parameter int R                = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [R*W_Y_OUT-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int NB     = calc_nb(W_Y_OUT, BITS_PER_WORD);
   localparam int WB     = NB * BITS_PER_WORD;
   localparam int NBYTES = R * NB;
   localparam int BC_W   = cnt_w(NBYTES - 1);

   logic [R*W_Y_OUT-1:0]                    vec_q, vec_d;
   logic [BC_W-1:0]                         cnt_q, cnt_d;
   logic                                    rdy_q, rdy_d;
   logic                                    sent_q, sent_d;
   logic [NBYTES-1:0][BITS_PER_WORD-1:0]    ext;
   logic                                    byte_vld, byte_rdy, frame_end;

   always_comb begin
      ext = '0;
      for (int r = 0; r < R; r++) begin
         ext[r*NB +: NB] = WB'($signed(vec_q[r*W_Y_OUT +: W_Y_OUT]));
      end
   end

   // sent_q: final byte handed to the serialiser, vector ends with that frame
   assign byte_vld = !rdy_q && !sent_q;
   assign s_ready  = rdy_q;
   assign busy     = !rdy_q;

   always_comb begin
      vec_d  = vec_q;
      cnt_d  = cnt_q;
      rdy_d  = rdy_q;
      sent_d = sent_q;
      if (s_valid && rdy_q) begin
         vec_d  = s_data;
         cnt_d  = '0;
         rdy_d  = 1'b0;
         sent_d = 1'b0;
      end else if (!rdy_q) begin
         if (byte_vld && byte_rdy) begin
            if (cnt_q == BC_W'(NBYTES - 1)) sent_d = 1'b1;
            else                             cnt_d  = cnt_q + BC_W'(1);
         end
         if (sent_q && frame_end) rdy_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q  <= '0;
         cnt_q  <= '0;
         rdy_q  <= 1'b1;
         sent_q <= 1'b0;
      end else begin
         vec_q  <= vec_d;
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
         sent_q <= sent_d;
      end
   end

   uart_tx_frame #(
      .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
      .BITS_PER_WORD   (BITS_PER_WORD),
      .PACKET_SIZE_TX  (PACKET_SIZE_TX)
   ) u_frame (
      .clk_i      (clk),
      .rst_i      (rst),
      .byte_dat_i (ext[cnt_q]),
      .byte_vld_i (byte_vld),
      .byte_rdy_o (byte_rdy),
      .frame_end_o(frame_end),
      .tx_o       (tx)
   );

endmodule

// File: tb/tb_mvm_uart_tx_packer.sv
// Directed bench: decodes tx mid-bit against a byte scoreboard filled when vectors are driven.
// Three instances cover baud dividers 4 (default), 1 and 7; parity expectations follow UART_TX_PARITY_EN.
module tb_mvm_uart_tx_packer;

   localparam int P   = 13;
   localparam int NBY = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [39:0] s_data  [3];
   logic        s_valid [3];
   logic        s_ready [3];
   logic        tx      [3];
   logic        busy    [3];

   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mvm_uart_tx_packer u_dut (
      .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]),
      .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]));

   mvm_uart_tx_packer #(.CLOCKS_PER_PULSE(1)) u_dut1 (
      .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]),
      .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]));

   mvm_uart_tx_packer #(.CLOCKS_PER_PULSE(7)) u_dut7 (
      .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]),
      .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_to(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [12:0] exp_frame(input logic [7:0] b);
      logic [12:0] f;
      f      = 13'h1FFF;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   task automatic push_vec(input logic [39:0] v);
      logic [9:0]  w;
      logic [15:0] e;
      for (int i = 0; i < 4; i++) begin
         w = v[i*10 +: 10];
         e = {{6{w[9]}}, w};
         exp_q.push_back(e[7:0]);
         exp_q.push_back(e[15:8]);
      end
   endtask

   task automatic send(input int i, input logic [39:0] v, input string tag, output int e0);
      chk({tag, "_rdy_before"}, 32'(s_ready[i]), 1);
      s_data[i]  = v;
      s_valid[i] = 1'b1;
      push_vec(v);
      @(posedge clk);
      #1;
      e0         = cyc;
      s_valid[i] = 1'b0;
   endtask

   task automatic recv_vec(input int i, input int cpp, input int e0, input string tag);
      logic [12:0] f;
      logic [7:0]  eb;
      for (int b = 0; b < NBY; b++) begin
         for (int k = 0; k < P; k++) begin
            step_to(e0 + 1 + (b * P + k) * cpp + cpp / 2);
            f[k] = tx[i];
         end
         if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 1);
         end else begin
            eb = exp_q.pop_front();
            chk($sformatf("%s_byte%0d", tag, b), 32'(f), 32'(exp_frame(eb)));
         end
      end
   endtask

   task automatic chk_end(input int i, input int cpp, input int e0, input string tag);
      step_to(e0 + NBY * P * cpp);
      chk({tag, "_rdy_low_last"}, 32'(s_ready[i]), 0);
      step_to(e0 + 1 + NBY * P * cpp);
      chk({tag, "_rdy_back"}, 32'(s_ready[i]), 1);
      chk({tag, "_busy_clr"}, 32'(busy[i]), 0);
      chk({tag, "_tx_idle"}, 32'(tx[i]), 1);
   endtask

   initial begin
      int e0, e0b, nedge;
      logic [39:0] vb;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_valid[i] = 1'b0;
         s_data[i]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(tx[0]), 1);
      chk("rst_ready", 32'(s_ready[0]), 1);
      chk("rst_busy", 32'(busy[0]), 0);
      rst = 1'b0;

      nedge = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (tx[0] !== 1'b1) nedge++;
      end
      chk("idle_tx_quiet", 32'(nedge), 0);

      send(0, {10'h000, 10'h000, 10'h155, 10'h3FF}, "t2", e0);
      chk("t2_tx_high_at_hs", 32'(tx[0]), 1);
      chk("t2_busy", 32'(busy[0]), 1);
      step_to(e0 + 1);
      chk("t2_start_bit", 32'(tx[0]), 0);
      recv_vec(0, 4, e0, "t2");
      chk_end(0, 4, e0, "t2");

      send(0, {10'h000, 10'h000, 10'h1FF, 10'h200}, "t3", e0);
      recv_vec(0, 4, e0, "t3");
      chk_end(0, 4, e0, "t3");

      vb = {10'h0AA, 10'h3C0, 10'h011, 10'h2FE};
      send(0, {10'h123, 10'h2AB, 10'h07F, 10'h301}, "t4", e0);
      fork
         recv_vec(0, 4, e0, "t4a");
         begin
            step_to(e0 + 50);
            s_data[0]  = vb;
            s_valid[0] = 1'b1;
            push_vec(vb);
         end
      join
      step_to(e0 + NBY * P * 4);
      chk("t4_rdy_low_last", 32'(s_ready[0]), 0);
      step_to(e0 + 1 + NBY * P * 4);
      chk("t4_rdy_back", 32'(s_ready[0]), 1);
      step_to(e0 + 2 + NBY * P * 4);
      e0b        = cyc;
      s_valid[0] = 1'b0;
      chk("t4_second_taken", 32'(s_ready[0]), 0);
      step_to(e0b + 1);
      chk("t4_second_start", 32'(tx[0]), 0);
      recv_vec(0, 4, e0b, "t4b");
      chk_end(0, 4, e0b, "t4b");

      send(0, {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, "t5", e0);
      step_to(e0 + 100);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_rst_tx", 32'(tx[0]), 1);
      chk("t5_rst_ready", 32'(s_ready[0]), 1);
      chk("t5_rst_busy", 32'(busy[0]), 0);
      rst = 1'b0;
      exp_q.delete();
      send(0, {10'h001, 10'h100, 10'h2C3, 10'h05A}, "t5b", e0);
      recv_vec(0, 4, e0, "t5b");
      chk_end(0, 4, e0, "t5b");

      send(1, {10'h000, 10'h3F8, 10'h003, 10'h007}, "t6c1", e0);
      step_to(e0 + 1);
      chk("t6c1_start_bit", 32'(tx[1]), 0);
      recv_vec(1, 1, e0, "t6c1");
      chk_end(1, 1, e0, "t6c1");

      send(2, {10'h000, 10'h3F8, 10'h003, 10'h007}, "t6c7", e0);
      step_to(e0 + 1);
      chk("t6c7_start_bit", 32'(tx[2]), 0);
      recv_vec(2, 7, e0, "t6c7");
      chk_end(2, 7, e0, "t6c7");

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
